// File: rtl/alu.sv
// rtl/alu.sv - XLEN-bit integer ALU with registered copies of its outputs; shifts built only under ALU_SHIFT_EN
package riscv_32i_defs_pkg;
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_t;
endpackage

// Bundle of all ALU ports with views for the DUT and for passive observers
interface alu_intf #(
   parameter int XLEN = 32
);
   import riscv_32i_defs_pkg::*;

   logic            clk;
   logic            rst_n;
   alu_op_t         alu_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            op_err;
   logic [XLEN-1:0] result_q;
   logic            zero_q;
   logic            op_err_q;

   modport dut (
      input  clk, rst_n, alu_op, in_a, in_b,
      output result, zero, op_err, result_q, zero_q, op_err_q
   );

   modport assertion (
      input clk, rst_n, alu_op, in_a, in_b,
      input result, zero, op_err, result_q, zero_q, op_err_q
   );

   modport coverage (
      input clk, rst_n, alu_op, in_a, in_b,
      input result, zero, op_err, result_q, zero_q, op_err_q
   );
endinterface

module alu
   import riscv_32i_defs_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  alu_op_t         alu_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            op_err,
   output logic [XLEN-1:0] result_q,
   output logic            zero_q,
   output logic            op_err_q
);

   logic [XLEN-1:0] result_d;
   logic            zero_d;
   logic            op_err_d;

`ifdef ALU_SHIFT_EN
   // Only the low five bits of operand B select the shift distance
   logic [4:0] shamt;
   assign shamt = in_b[4:0];
`endif

   // Operation decode; any encoding not built into this configuration yields 0 and raises op_err
   always_comb begin
      result_d = '0;
      op_err_d = 1'b0;
      case (alu_op)
         ALU_AND:  result_d = in_a & in_b;
         ALU_OR:   result_d = in_a | in_b;
         ALU_XOR:  result_d = in_a ^ in_b;
         ALU_ADD:  result_d = in_a + in_b;
         ALU_SUB:  result_d = in_a - in_b;
         ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, (in_a < in_b)};
`ifdef ALU_SHIFT_EN
         ALU_SLL:  result_d = in_a << shamt;
         ALU_SRL:  result_d = in_a >> shamt;
         ALU_SRA:  result_d = $unsigned($signed(in_a) >>> shamt);
`endif
         default:  op_err_d = 1'b1;
      endcase
      zero_d = (result_d == '0);
   end

   assign result = result_d;
   assign zero   = zero_d;
   assign op_err = op_err_d;

   // Output register loads every cycle; reset forces the "result is zero, no error" state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         op_err_q <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         op_err_q <= op_err_d;
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: directed vectors, reset behaviour, random sweep against a model
module tb_alu;
   import riscv_32i_defs_pkg::*;

   alu_intf #(.XLEN(32)) bus ();

   int n_checks = 0;
   int n_errors = 0;

   alu #(.XLEN(32)) dut (
      .clk      (bus.clk),
      .rst_n    (bus.rst_n),
      .alu_op   (bus.alu_op),
      .in_a     (bus.in_a),
      .in_b     (bus.in_b),
      .result   (bus.result),
      .zero     (bus.zero),
      .op_err   (bus.op_err),
      .result_q (bus.result_q),
      .zero_q   (bus.zero_q),
      .op_err_q (bus.op_err_q)
   );

   initial bus.clk = 1'b0;
   always #5 bus.clk = ~bus.clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic bit shifts_built();
`ifdef ALU_SHIFT_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_err(input logic [3:0] op);
      if (op > 4'd9) return 1'b1;
      if (!shifts_built() && (op == 4'd4 || op == 4'd5 || op == 4'd7)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] fill;
      int          sh;
      sh = int'(b[4:0]);
      if (model_err(op)) return 32'h0;
      case (op)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a ^ b;
         4'd4: return a << sh;
         4'd5: return a >> sh;
         4'd6: return a + ~b + 32'd1;
         4'd7: begin
            fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
            return (a >> sh) | fill;
         end
         4'd8: return (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, (a < b)};
         4'd9: return {31'h0, (a < b)};
         default: return 32'h0;
      endcase
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge bus.clk);
      bus.alu_op = alu_op_t'(op);
      bus.in_a   = a;
      bus.in_b   = b;
      #1;
   endtask

   task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic exp_z, input logic exp_e);
      drive(op, a, b);
      check({tag, "_result"}, bus.result, exp_r);
      check({tag, "_zero"}, bus.zero, exp_z);
      check({tag, "_op_err"}, bus.op_err, exp_e);
      @(posedge bus.clk);
      #1;
      check({tag, "_result_q"}, bus.result_q, exp_r);
      check({tag, "_zero_q"}, bus.zero_q, exp_z);
      check({tag, "_op_err_q"}, bus.op_err_q, exp_e);
   endtask

   initial begin
      logic [31:0] a, b, er;
      logic        ez, ee;

      bus.rst_n  = 1'b1;
      bus.alu_op = ALU_AND;
      bus.in_a   = 32'h0;
      bus.in_b   = 32'h0;
      #2;
      bus.rst_n = 1'b0;
      #1;
      check("rst_result_q", bus.result_q, 32'h0);
      check("rst_zero_q", bus.zero_q, 1'b1);
      check("rst_op_err_q", bus.op_err_q, 1'b0);
      @(negedge bus.clk);
      @(negedge bus.clk);
      bus.rst_n = 1'b1;

      vec("and",   4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
      vec("or0",   4'd1, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0);
      vec("xor",   4'd3, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
      vec("addwr", 4'd2, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
      vec("addov", 4'd2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0);
      vec("subeq", 4'd6, 32'h1234_5678, 32'h1234_5678, 32'h0,         1'b1, 1'b0);
      vec("subbr", 4'd6, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0);
      vec("slt",   4'd8, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0);
      vec("sltu",  4'd9, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
`ifdef ALU_SHIFT_EN
      vec("sra",   4'd7, 32'h8000_0000, 32'h1F,        32'hFFFF_FFFF, 1'b0, 1'b0);
      vec("sll",   4'd4, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 1'b0, 1'b0);
      vec("srl",   4'd5, 32'h8000_0000, 32'h1F,        32'h0000_0001, 1'b0, 1'b0);
`else
      vec("sra_off", 4'd7, 32'h8000_0000, 32'h1F, 32'h0, 1'b1, 1'b1);
      vec("sll_off", 4'd4, 32'h0000_0003, 32'h4,  32'h0, 1'b1, 1'b1);
      vec("srl_off", 4'd5, 32'h8000_0000, 32'h1,  32'h0, 1'b1, 1'b1);
`endif
      vec("bad_a", 4'd10, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
      vec("bad_f", 4'd15, $urandom, $urandom, 32'h0, 1'b1, 1'b1);

      // Mid-run asynchronous reset: registered outputs clear between edges, combinational outputs untouched
      drive(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      @(posedge bus.clk);
      #2;
      bus.rst_n = 1'b0;
      #1;
      check("arst_result_q", bus.result_q, 32'h0);
      check("arst_zero_q", bus.zero_q, 1'b1);
      check("arst_op_err_q", bus.op_err_q, 1'b0);
      check("arst_comb_result", bus.result, 32'hF000_F000);
      check("arst_comb_zero", bus.zero, 1'b0);
      @(negedge bus.clk);
      bus.alu_op = alu_op_t'(4'd15);
      bus.rst_n  = 1'b1;
      #1;
      check("rel_hold_result_q", bus.result_q, 32'h0);
      check("rel_hold_op_err_q", bus.op_err_q, 1'b0);
      @(posedge bus.clk);
      #1;
      check("rel_load_op_err_q", bus.op_err_q, 1'b1);
      check("rel_load_zero_q", bus.zero_q, 1'b1);

      // Random sweep over every encoding, with operand pairs biased toward equality and sign differences
      for (int op = 0; op < 16; op++) begin
         for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) b = a;
            if (i % 8 == 1) b = a ^ 32'h8000_0000;
            if (i % 8 == 2) b = {27'h0, b[4:0]};
            er = model_res(op[3:0], a, b);
            ez = (er == 32'h0);
            ee = model_err(op[3:0]);
            drive(op[3:0], a, b);
            check("rnd_result", bus.result, er);
            check("rnd_zero", bus.zero, ez);
            check("rnd_op_err", bus.op_err, ee);
            @(posedge bus.clk);
            #1;
            check("rnd_result_q", bus.result_q, er);
            check("rnd_zero_q", bus.zero_q, ez);
            check("rnd_op_err_q", bus.op_err_q, ee);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, sampled on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port alu_op, input, 4 bits: operation select, typed alu_op_t from riscv_32i_defs_pkg.
REQ-005 The block SHALL have port in_a, input, XLEN bits: operand A.
REQ-006 The block SHALL have port in_b, input, XLEN bits: operand B.
REQ-007 The block SHALL have port result, output, XLEN bits: combinational result.
REQ-008 The block SHALL have port zero, output, 1 bit: combinational flag, 1 when result == 0.
REQ-009 The block SHALL have port op_err, output, 1 bit: combinational flag, 1 when alu_op is unsupported.
REQ-010 The block SHALL have port result_q, output, XLEN bits: registered copy of result.
REQ-011 The block SHALL have port zero_q, output, 1 bit: registered copy of zero.
REQ-012 The block SHALL have port op_err_q, output, 1 bit: registered copy of op_err.
REQ-013 The block SHALL connect to the verification environment through interface alu_intf, which carries all ports above and provides modports for dut, assertion and coverage.

Function
REQ-014 alu_op encodings SHALL be: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_XOR=0011, ALU_SLL=0100, ALU_SRL=0101, ALU_SUB=0110, ALU_SRA=0111, ALU_SLT=1000, ALU_SLTU=1001.
REQ-015 AND, OR and XOR SHALL compute the bitwise function of in_a and in_b.
REQ-016 ADD SHALL compute in_a+in_b modulo 2^XLEN, with carry-out discarded and no overflow flag.
REQ-017 SUB SHALL compute in_a-in_b modulo 2^XLEN, wrapping on borrow.
REQ-018 SLL and SRL SHALL shift in_a logically left or right by in_b[4:0]; bits in_b[XLEN-1:5] SHALL be ignored.
REQ-019 SRA SHALL shift in_a right arithmetically by in_b[4:0], replicating in_a[XLEN-1].
REQ-020 SLT SHALL output 1 when in_a < in_b as signed values, else 0, zero-extended to XLEN.
REQ-021 SLTU SHALL output 1 when in_a < in_b as unsigned values, else 0, zero-extended to XLEN.
REQ-022 For any unlisted encoding (including 1010-1111), result SHALL be 0, zero SHALL be 1 and op_err SHALL be 1.
REQ-023 For every listed encoding, op_err SHALL be 0.
REQ-024 result, zero and op_err SHALL be purely combinational from alu_op, in_a and in_b (latency 0, no clock dependence), with no latches and no X on output for any known input.
REQ-025 result_q, zero_q and op_err_q SHALL load result, zero and op_err on every rising edge of clk (latency 1 cycle); there is no enable and no handshake.

Reset
REQ-026 While rst_n=0, result_q SHALL be 0, zero_q SHALL be 1 and op_err_q SHALL be 0, asserted asynchronously on the falling edge of rst_n.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first edge after release SHALL load the current combinational values.
REQ-028 Reset SHALL NOT affect the combinational outputs result, zero or op_err.

Configuration
REQ-029 When macro ALU_SHIFT_EN is defined, SLL, SRL and SRA SHALL be implemented per REQ-018 and REQ-019.
REQ-030 When ALU_SHIFT_EN is undefined, encodings 0100, 0101 and 0111 SHALL behave as invalid ops per REQ-022, and no shifter logic SHALL be synthesized.

Verification
REQ-031 A bench SHALL check: AND with in_a=F0F0F0F0, in_b=FF00FF00 -> result=F000F000, zero=0; OR with in_a=0, in_b=0 -> result=0, zero=1.
REQ-032 A bench SHALL check: ADD with in_a=FFFFFFFF, in_b=1 -> result=0, zero=1; ADD with in_a=7FFFFFFF, in_b=1 -> result=80000000, zero=0.
REQ-033 A bench SHALL check: SUB with in_a=in_b=12345678 -> result=0, zero=1; SUB with in_a=0, in_b=1 -> result=FFFFFFFF.
REQ-034 A bench SHALL check: SLT with in_a=FFFFFFFF, in_b=1 -> result=1; SLTU with the same operands -> result=0; with ALU_SHIFT_EN defined, SRA with in_a=80000000, in_b=1F -> result=FFFFFFFF.
REQ-035 A bench SHALL check: alu_op=1111 with random operands -> result=0, zero=1, op_err=1; one clk edge later, op_err_q=1.
REQ-036 A bench SHALL check: assert rst_n=0 mid-run -> result_q=0, zero_q=1, op_err_q=0 immediately, without waiting for a clock edge.
REQ-037 A bench SHALL check: 1000 or more random transactions per op compared against the reference model, with zero cycle latency on the combinational outputs and one cycle latency on the registered outputs.
